// File: rtl/instruction_fetch.sv
// Fetch stage: owns PC and IR, runs the enable/busy handshake with the
// instruction ROM and hands opcode/funct3/funct7 to the ControlUnit.
module instruction_fetch #(
    parameter int          addr_size = 8,
    parameter logic [63:0] reset_pc  = 64'h0,
    parameter int          timeout   = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 fetch_start,
    output logic                 fetch_done,
    output logic                 fetch_error,
    input  logic                 pc_enable,
    input  logic [63:0]          pc_in,
    output logic [63:0]          pc,
    output logic                 mem_enable,
    output logic [addr_size-1:0] mem_addr,
    input  logic [31:0]          mem_data,
    input  logic                 mem_busy,
    output logic [31:0]          instruction,
    output logic [6:0]           opcode,
    output logic [2:0]           funct3,
    output logic [6:0]           funct7
);

    localparam int                 cnt_w    = $clog2(timeout + 1);
    localparam logic [cnt_w-1:0]   cnt_last = cnt_w'(timeout - 1);
    localparam logic [cnt_w-1:0]   cnt_one  = cnt_w'(1);
    localparam logic [31:0]        nop_ir   = 32'h00000013;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQUEST = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    state_t               state_r, state_s;
    logic [63:0]          pc_r, pc_s;
    logic [31:0]          ir_r, ir_s;
    logic [cnt_w-1:0]     cnt_r, cnt_s;
    logic                 busy_seen_r, busy_seen_s;
    // Address latched when a fetch is accepted, so a PC load on the same
    // edge does not redirect the access already under way.
    logic [addr_size-1:0] addr_r, addr_s;
    logic                 fetch_done_r;
    logic                 fetch_error_r;
    logic                 mem_enable_r;

    // Next-state, PC/IR update and handshake bookkeeping.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        ir_s        = ir_r;
        cnt_s       = cnt_r;
        busy_seen_s = busy_seen_r;
        addr_s      = addr_r;
        case (state_r)
            ST_IDLE: begin
                if (pc_enable) begin
                    pc_s = pc_in;
                end else begin
                    pc_s = pc_r;
                end
                if (fetch_start) begin
                    addr_s = pc_r[addr_size-1:0];
                    if (pc_r[1:0] != 2'b00) begin
                        state_s = ST_ERROR;
                    end else begin
                        state_s = ST_REQUEST;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQUEST: begin
                busy_seen_s = 1'b0;
                cnt_s       = {cnt_w{1'b0}};
                state_s     = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_s = cnt_r + cnt_one;
                if (mem_busy) begin
                    busy_seen_s = 1'b1;
                end else begin
                    busy_seen_s = busy_seen_r;
                end
                if (busy_seen_r && !mem_busy) begin
                    ir_s    = mem_data;
                    state_s = ST_DONE;
                end else if (cnt_r == cnt_last) begin
                    state_s = ST_ERROR;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            ST_ERROR: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath registers and registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            pc_r          <= reset_pc;
            ir_r          <= nop_ir;
            cnt_r         <= {cnt_w{1'b0}};
            busy_seen_r   <= 1'b0;
            addr_r        <= {addr_size{1'b0}};
            fetch_done_r  <= 1'b0;
            fetch_error_r <= 1'b0;
            mem_enable_r  <= 1'b0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            ir_r          <= ir_s;
            cnt_r         <= cnt_s;
            busy_seen_r   <= busy_seen_s;
            addr_r        <= addr_s;
            fetch_done_r  <= (state_s == ST_DONE);
            fetch_error_r <= (state_s == ST_ERROR);
            mem_enable_r  <= (state_s == ST_REQUEST) || (state_s == ST_WAIT);
        end
    end

    assign pc          = pc_r;
    assign instruction = ir_r;
    assign opcode      = ir_r[6:0];
    assign funct3      = ir_r[14:12];
    assign funct7      = ir_r[31:25];
    assign fetch_done  = fetch_done_r;
    assign fetch_error = fetch_error_r;
    assign mem_enable  = mem_enable_r;
    assign mem_addr    = (state_r == ST_IDLE) ? pc_r[addr_size-1:0] : addr_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: vector table plus hand-written
// corner-case sequences, results matched through a scoreboard queue.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic        fetch_done;
    logic        fetch_error;
    logic        pc_enable;
    logic [63:0] pc_in;
    logic [63:0] pc;
    logic        mem_enable;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_busy = 1'b0;
    logic [31:0] instruction;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    instruction_fetch dut (
        .clock(clock), .reset(reset), .fetch_start(fetch_start),
        .fetch_done(fetch_done), .fetch_error(fetch_error),
        .pc_enable(pc_enable), .pc_in(pc_in), .pc(pc),
        .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_busy(mem_busy), .instruction(instruction), .opcode(opcode),
        .funct3(funct3), .funct7(funct7)
    );

    always #5 clock = ~clock;

    // ROM model: word-addressed, busy for busy_cycles after enable rises
    logic [31:0] rom [0:63];
    int          busy_cycles = 0;
    int          busy_left   = 0;
    bit          rom_active  = 1'b0;
    bit          stuck_busy  = 1'b0;

    assign mem_data = rom[mem_addr[7:2]];

    always @(posedge clock) begin
        if (stuck_busy) begin
            mem_busy   <= 1'b1;
            rom_active <= 1'b0;
        end else if (mem_enable && !rom_active) begin
            rom_active <= 1'b1;
            busy_left  <= busy_cycles;
            mem_busy   <= (busy_cycles > 0);
        end else if (mem_enable && rom_active) begin
            if (busy_left > 0) busy_left <= busy_left - 1;
            mem_busy <= (busy_left > 1);
        end else begin
            rom_active <= 1'b0;
            mem_busy   <= 1'b0;
        end
    end

    // Pulse counters and enable monitor, sampled on the active edge
    int done_cnt = 0;
    int err_cnt  = 0;
    bit en_seen  = 1'b0;
    always @(posedge clock) begin
        if (fetch_done)  done_cnt = done_cnt + 1;
        if (fetch_error) err_cnt  = err_cnt + 1;
        if (mem_enable)  en_seen  = 1'b1;
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act === exp) passed = passed + 1;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        logic [31:0] ir;
        logic        err;
    } sb_t;
    sb_t exp_q[$];

    typedef struct {
        logic [63:0] pc_val;
        int          busy;
        logic        exp_err;
        logic [31:0] exp_ir;
        logic [6:0]  exp_op;
        logic [2:0]  exp_f3;
        logic [6:0]  exp_f7;
        logic [7:0]  exp_addr;
    } vec_t;
    vec_t vecs[6];

    task automatic load_pc(input logic [63:0] v);
        pc_enable = 1'b1;
        pc_in     = v;
        @(negedge clock);
        pc_enable = 1'b0;
        check("pc_load", pc, v);
    endtask

    // Called just after a negedge; starts a fetch and waits for its result.
    task automatic run_fetch(input logic [31:0] exp_ir, input logic exp_err, input int exp_lat,
                             input logic hold_pc_en, input string nm, output logic [7:0] first_addr);
        sb_t e;
        int  lat = 0;
        bit  seen = 1'b0;
        int  en_bad = 0;
        int  d0 = done_cnt;
        int  e0 = err_cnt;
        en_seen = 1'b0;
        exp_q.push_back('{exp_ir, exp_err});
        fetch_start = 1'b1;
        @(negedge clock);
        fetch_start = 1'b0;
        first_addr  = mem_addr;
        if (hold_pc_en) begin
            pc_enable = 1'b1;
            pc_in     = 64'h20;
        end else begin
            pc_enable = 1'b0;
        end
        for (int i = 0; i < 300; i++) begin
            if (fetch_done || fetch_error) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
            if (!mem_enable) en_bad++;
            @(negedge clock);
        end
        pc_enable = 1'b0;
        e = exp_q.pop_front();
        if (!seen) begin
            check({nm, "_completes"}, 64'd0, 64'd1);
            return;
        end
        check({nm, "_err"}, fetch_error, e.err);
        check({nm, "_ir"}, instruction, e.ir);
        check({nm, "_latency"}, lat, exp_lat);
        check({nm, "_en_held"}, en_bad, 0);
        check({nm, "_en_low_at_end"}, mem_enable, 1'b0);
        if (exp_err && exp_lat == 0) check({nm, "_no_rom_access"}, en_seen, 1'b0);
        @(negedge clock);
        check({nm, "_pulse_width"}, {fetch_done, fetch_error}, 2'b00);
        check({nm, "_done_count"}, done_cnt - d0, exp_err ? 0 : 1);
        check({nm, "_err_count"}, err_cnt - e0, exp_err ? 1 : 0);
    endtask

    initial begin
        logic [7:0] a;
        int d0;
        for (int i = 0; i < 64; i++) rom[i] = 32'h00000013;
        rom[0] = 32'h00500093;
        rom[1] = 32'h00a00113;
        rom[2] = 32'h002081b3;
        rom[3] = 32'h40208233;
        rom[4] = 32'h0000a283;

        vecs[0] = '{64'h0,   12, 1'b0, 32'h00500093, 7'b0010011, 3'b000, 7'b0000000, 8'h00};
        vecs[1] = '{64'h8,    3, 1'b0, 32'h002081b3, 7'b0110011, 3'b000, 7'b0000000, 8'h08};
        vecs[2] = '{64'hC,    1, 1'b0, 32'h40208233, 7'b0110011, 3'b000, 7'b0100000, 8'h0C};
        vecs[3] = '{64'h10,   5, 1'b0, 32'h0000a283, 7'b0000011, 3'b010, 7'b0000000, 8'h10};
        vecs[4] = '{64'h6,    2, 1'b1, 32'h0000a283, 7'b0000011, 3'b010, 7'b0000000, 8'h06};
        vecs[5] = '{64'h104,  2, 1'b0, 32'h00a00113, 7'b0010011, 3'b000, 7'b0000000, 8'h04};

        reset = 1'b1; fetch_start = 1'b0; pc_enable = 1'b0; pc_in = 64'h0;
        repeat (2) @(negedge clock);
        check("reset_pc", pc, 64'h0);
        check("reset_ir", instruction, 32'h00000013);
        check("reset_mem_enable", mem_enable, 1'b0);
        check("reset_fetch_done", fetch_done, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        // Table-driven fetches
        foreach (vecs[k]) begin
            load_pc(vecs[k].pc_val);
            busy_cycles = vecs[k].busy;
            run_fetch(vecs[k].exp_ir, vecs[k].exp_err, vecs[k].exp_err ? 0 : vecs[k].busy + 2,
                      1'b0, $sformatf("vec%0d", k), a);
            check($sformatf("vec%0d_addr", k), a, vecs[k].exp_addr);
            check($sformatf("vec%0d_opcode", k), opcode, vecs[k].exp_op);
            check($sformatf("vec%0d_funct3", k), funct3, vecs[k].exp_f3);
            check($sformatf("vec%0d_funct7", k), funct7, vecs[k].exp_f7);
            check($sformatf("vec%0d_pc_kept", k), pc, vecs[k].pc_val);
        end

        // fetch_start with pc_enable: old PC (0x104) fetched, PC becomes 8
        busy_cycles = 2;
        pc_enable = 1'b1;
        pc_in     = 64'h8;
        run_fetch(32'h00a00113, 1'b0, 4, 1'b0, "start_and_load", a);
        check("start_and_load_addr", a, 8'h04);
        check("start_and_load_pc", pc, 64'h8);

        // pc_enable held during the access is ignored
        busy_cycles = 4;
        run_fetch(32'h002081b3, 1'b0, 6, 1'b1, "pc_en_in_wait", a);
        check("pc_en_in_wait_pc", pc, 64'h8);

        // ROM stuck busy: timeout error after 64 WAIT cycles, IR unchanged
        stuck_busy = 1'b1;
        run_fetch(32'h002081b3, 1'b1, 65, 1'b0, "timeout", a);
        stuck_busy = 1'b0;
        load_pc(64'h0);
        busy_cycles = 2;
        run_fetch(32'h00500093, 1'b0, 4, 1'b0, "after_timeout", a);

        // Reset in the middle of WAIT abandons the access
        load_pc(64'hC);
        busy_cycles = 20;
        fetch_start = 1'b1;
        @(negedge clock);
        fetch_start = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_mem_enable", mem_enable, 1'b0);
        check("midreset_pc", pc, 64'h0);
        check("midreset_ir", instruction, 32'h00000013);
        check("midreset_done", fetch_done, 1'b0);
        reset = 1'b0;
        d0 = done_cnt;
        repeat (30) @(negedge clock);
        check("midreset_no_done", done_cnt - d0, 0);
        check("midreset_idle_enable", mem_enable, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
